// File: rtl/wr_coalesce_buf.sv
// -----------------------------------------------------------------------------
// wr_coalesce_buf
//
// Write-combining stage that sits directly in front of the block memory's
// write port. Single SIZE-bit element stores arrive over a valid/ready
// handshake. Runs of consecutive addresses are merged into one block write
// of 1..BLOCK_SIZE elements. The block outputs connect straight to the
// memory's i_addr_w / i_data_w / i_wr_size / i_wr_en.
//
// Optional build macro:
//   WRC_TIMEOUT_EN  - when defined, a partial block that sees no accepted
//                     store for TIMEOUT consecutive FILL cycles is flushed
//                     automatically. When undefined, a partial block leaves
//                     FILL only when it is full, when a non-contiguous store
//                     arrives, or on i_flush.
//
// Ports:
//   i_clk      in   1                   clock, rising edge
//   i_rst_n    in   1                   synchronous reset, active low
//   i_valid    in   1                   store request valid
//   o_ready    out  1                   store accepted when i_valid & o_ready
//   i_addr     in   ADDR_SIZE           store element address
//   i_data     in   SIZE                store element data
//   i_flush    in   1                   force out any partial block
//   o_addr_w   out  ADDR_SIZE           block base address
//   o_data_w   out  SIZE*BLOCK_SIZE     packed block; element k sits at
//                                       [(BLOCK_SIZE-k)*SIZE-1 -: SIZE]
//   o_wr_size  out  $clog2(BLOCK_SIZE)  valid elements in block
//   o_wr_en    out  1                   one-cycle block write strobe
//   o_busy     out  1                   buffer holds at least one element
//
// State table:
//   state   | meaning
//   S_IDLE  | buffer empty, any store is accepted and opens a new block
//   S_FILL  | 1..BLOCK_SIZE-1 elements held, waiting for the next one
//   S_FLUSH | block presented to the memory with o_wr_en high for one cycle
// -----------------------------------------------------------------------------
module wr_coalesce_buf #(
    parameter int unsigned SIZE       = 32,
    parameter int unsigned BLOCK_SIZE = 5,
    parameter int unsigned ADDR_SIZE  = 24,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [ADDR_SIZE-1:0]          i_addr,
    input  logic [SIZE-1:0]               i_data,
    input  logic                          i_flush,
    output logic [ADDR_SIZE-1:0]          o_addr_w,
    output logic [SIZE*BLOCK_SIZE-1:0]    o_data_w,
    output logic [$clog2(BLOCK_SIZE)-1:0] o_wr_size,
    output logic                          o_wr_en,
    output logic                          o_busy
);

    localparam int unsigned CW = $clog2(BLOCK_SIZE);

    // A full block's count (BLOCK_SIZE) must still fit in CW bits.
    if ((BLOCK_SIZE & (BLOCK_SIZE - 1)) == 0) begin : g_bad_block_size
        $error("wr_coalesce_buf: BLOCK_SIZE must not be a power of two");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("wr_coalesce_buf: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CW-1:0]       count_q;
    logic [ADDR_SIZE-1:0] base_q;
    logic [SIZE-1:0]     lane_q [BLOCK_SIZE];

    logic [ADDR_SIZE:0]  next_addr;
    logic                contig;
    logic                last_slot;
    logic                accept;
    logic                timeout_hit;

    // One extra bit catches a run that would wrap past the top of the
    // address space; such a store starts a new block instead.
    assign next_addr = {1'b0, base_q} + {{(ADDR_SIZE + 1 - CW){1'b0}}, count_q};
    assign contig    = !next_addr[ADDR_SIZE] && (next_addr[ADDR_SIZE-1:0] == i_addr);
    assign last_slot = (count_q == CW'(BLOCK_SIZE - 1));

`ifdef WRC_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // Idle timer: reloaded on every accept (including the one that opens
    // the block), counts down on FILL cycles without an accept. Reaching
    // zero means TIMEOUT-1 idle cycles have already elapsed, so this FILL
    // cycle is the last one before the block is forced out.
    logic [TW-1:0] idle_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            idle_q <= '0;
        end else if (accept) begin
            idle_q <= TW'(TIMEOUT - 1);
        end else if ((state_q == S_FILL) && (idle_q != '0)) begin
            idle_q <= idle_q - TW'(1);
        end
    end

    assign timeout_hit = (state_q == S_FILL) && (idle_q == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    accept  = 1'b1;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (i_flush) begin
                    state_d = S_FLUSH;
                end else if (i_valid) begin
                    if (contig) begin
                        o_ready = 1'b1;
                        accept  = 1'b1;
                        if (last_slot) begin
                            state_d = S_FLUSH;
                        end
                    end else begin
                        // The stalled store is taken in the IDLE cycle after
                        // the flush and becomes the next block's base.
                        state_d = S_FLUSH;
                    end
                end else if (timeout_hit) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Lanes are always cleared on the way back to IDLE, so an accept only
    // ever writes lane[count] and unfilled lanes read as zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            base_q  <= '0;
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == S_FLUSH) begin
                count_q <= '0;
                for (int k = 0; k < BLOCK_SIZE; k++) begin
                    lane_q[k] <= '0;
                end
            end else if (accept) begin
                if (state_q == S_IDLE) begin
                    base_q <= i_addr;
                end
                count_q <= count_q + CW'(1);
                for (int k = 0; k < BLOCK_SIZE; k++) begin
                    if (CW'(k) == count_q) begin
                        lane_q[k] <= i_data;
                    end
                end
            end
        end
    end

    always_comb begin
        o_data_w = '0;
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            o_data_w[(BLOCK_SIZE - k) * SIZE - 1 -: SIZE] = lane_q[k];
        end
    end

    assign o_addr_w  = base_q;
    assign o_wr_size = count_q;
    assign o_wr_en   = (state_q == S_FLUSH);
    assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_wr_coalesce_buf.sv
module tb_wr_coalesce_buf;

    localparam int SIZE = 32;
    localparam int BS   = 5;
    localparam int AW   = 24;
    localparam int DW   = SIZE * BS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   data = '0;

    logic          o_ready;
    logic [AW-1:0] o_addr_w;
    logic [DW-1:0] o_data_w;
    logic [2:0]    o_wr_size;
    logic          o_wr_en;
    logic          o_busy;

    wr_coalesce_buf #(
        .SIZE(32), .BLOCK_SIZE(5), .ADDR_SIZE(24), .TIMEOUT(16)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (valid),
        .o_ready  (o_ready),
        .i_addr   (addr),
        .i_data   (data),
        .i_flush  (flush),
        .o_addr_w (o_addr_w),
        .o_data_w (o_data_w),
        .o_wr_size(o_wr_size),
        .o_wr_en  (o_wr_en),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [2:0]    s;
    } wr_t;

    wr_t wr_log[$];

    // Model: the pending block is a base address plus a queue of words;
    // m_emit marks the cycle in which that block is being written out.
    longint      m_base = 0;
    logic [31:0] m_q[$];
    bit          m_emit = 1'b0;
    bit          cmp_en = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : p_cmp
        logic [DW-1:0] exp_d;
        bit empty;
        bit contig;
        bit exp_ready;
        if (cmp_en) begin
            empty  = (m_q.size() == 0);
            contig = !empty
                  && ((m_base + longint'(m_q.size())) < (64'sd1 <<< AW))
                  && ((m_base + longint'(m_q.size())) == longint'(addr));
            chk("cyc_wr_en", DW'(o_wr_en), DW'(m_emit));
            chk("cyc_busy", DW'(o_busy), DW'(!empty));
            exp_ready = m_emit ? 1'b0 : (empty ? 1'b1 : (!flush && valid && contig));
            if (valid || empty) chk("cyc_ready", DW'(o_ready), DW'(exp_ready));
            if (m_emit) begin
                exp_d = '0;
                foreach (m_q[k]) exp_d[(BS - k) * SIZE - 1 -: SIZE] = m_q[k];
                chk("cyc_addr_w", DW'(o_addr_w), DW'(m_base));
                chk("cyc_wr_size", DW'(o_wr_size), DW'(m_q.size()));
                chk("cyc_data_w", o_data_w, exp_d);
            end
            if (o_wr_en === 1'b1) wr_log.push_back('{o_addr_w, o_data_w, o_wr_size});

            if (!rst_n) begin
                m_q.delete();
                m_emit = 1'b0;
            end else if (m_emit) begin
                m_q.delete();
                m_emit = 1'b0;
            end else if (empty) begin
                if (valid) begin
                    m_base = longint'(addr);
                    m_q.push_back(data);
                end
            end else if (flush) begin
                m_emit = 1'b1;
            end else if (valid) begin
                if (contig) begin
                    m_q.push_back(data);
                    if (m_q.size() == BS) m_emit = 1'b1;
                end else begin
                    m_emit = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one store (optionally with i_flush on its first cycle) and
    // returns how many cycles it was on the bus including the accept cycle.
    task automatic store(input logic [AW-1:0] a, input logic [31:0] d, input bit fl, output int cyc);
        bit rdy;
        valid = 1'b1;
        addr  = a;
        data  = d;
        flush = fl;
        cyc   = 0;
        rdy   = 1'b0;
        do begin
            @(negedge clk);
            rdy = o_ready;
            tick();
            flush = 1'b0;
            cyc++;
        end while (!rdy && cyc < 20);
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL store_timeout actual=%0d cycles required=accept", cyc);
        end
        valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
    endtask

    task automatic expect_wr(input string n, input logic [AW-1:0] a, input int s, input logic [DW-1:0] d);
        wr_t w;
        if (wr_log.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_missing actual=none required=write", n);
        end else begin
            w = wr_log.pop_front();
            chk({n, "_addr"}, DW'(w.a), DW'(a));
            chk({n, "_size"}, DW'(w.s), DW'(s));
            chk({n, "_data"}, w.d, d);
        end
    endtask

    task automatic expect_none(input string n);
        chk(n, DW'(wr_log.size()), DW'(0));
    endtask

    task automatic chk_reset_outputs(input string n);
        chk({n, "_ready"}, DW'(o_ready), DW'(1));
        chk({n, "_wr_en"}, DW'(o_wr_en), DW'(0));
        chk({n, "_busy"}, DW'(o_busy), DW'(0));
        chk({n, "_addr_w"}, DW'(o_addr_w), DW'(0));
        chk({n, "_data_w"}, o_data_w, DW'(0));
        chk({n, "_wr_size"}, DW'(o_wr_size), DW'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int total;

        rst_n = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        tick();

        // 1: full block of five
        for (int k = 0; k < 5; k++) begin
            store(24'h10 + 24'(k), 32'hA00000A0 + 32'(k), 1'b0, cyc);
            chk("t1_accept_cycles", DW'(cyc), DW'(1));
        end
        chk("t1_wr_en", DW'(o_wr_en), DW'(1));
        chk("t1_ready", DW'(o_ready), DW'(0));
        tick();
        tick();
        expect_wr("t1", 24'h10, 5,
                  {32'hA00000A0, 32'hA00000A1, 32'hA00000A2, 32'hA00000A3, 32'hA00000A4});

        // 2: non-contiguous store closes a block of two
        store(24'h20, 32'hB00000B0, 1'b0, cyc);
        store(24'h21, 32'hB00000B1, 1'b0, cyc);
        store(24'h40, 32'hC00000C0, 1'b0, cyc);
        chk("t2_stall_cycles", DW'(cyc), DW'(3));
        expect_wr("t2a", 24'h20, 2, {32'hB00000B0, 32'hB00000B1, 96'h0});
        pulse_flush();
        expect_wr("t2b", 24'h40, 1, {32'hC00000C0, 128'h0});

        // 3: flush wins over a contiguous store in the same cycle
        store(24'h100, 32'hD00000D0, 1'b0, cyc);
        store(24'h101, 32'hD00000D1, 1'b0, cyc);
        store(24'h102, 32'hD00000D2, 1'b0, cyc);
        store(24'h103, 32'hD00000D3, 1'b1, cyc);
        chk("t3_stall_cycles", DW'(cyc), DW'(3));
        expect_wr("t3a", 24'h100, 3, {32'hD00000D0, 32'hD00000D1, 32'hD00000D2, 64'h0});
        pulse_flush();
        expect_wr("t3b", 24'h103, 1, {32'hD00000D3, 128'h0});

        // 4: reset mid-fill discards the partial block
        store(24'h300, 32'hE00000E0, 1'b0, cyc);
        store(24'h301, 32'hE00000E1, 1'b0, cyc);
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("t4");
        rst_n = 1'b1;
        repeat (10) tick();
        expect_none("t4_no_write");

        // 5: run may not wrap past the top of the address space
        store(24'hFFFFFF, 32'hF00000F0, 1'b0, cyc);
        store(24'h000000, 32'hF00000F1, 1'b0, cyc);
        chk("t5_stall_cycles", DW'(cyc), DW'(3));
        expect_wr("t5a", 24'hFFFFFF, 1, {32'hF00000F0, 128'h0});
        pulse_flush();
        expect_wr("t5b", 24'h000000, 1, {32'hF00000F1, 128'h0});

        // 6: a partial block is held while idle
        store(24'h500, 32'h55555555, 1'b0, cyc);
        repeat (100) tick();
        chk("t6_busy", DW'(o_busy), DW'(1));
        expect_none("t6_no_write");
        pulse_flush();
        expect_wr("t6", 24'h500, 1, {32'h55555555, 128'h0});

        // 7: flush while empty does nothing
        pulse_flush();
        chk("t7_busy", DW'(o_busy), DW'(0));
        expect_none("t7_no_write");

        // 8: sustained stream, five words per six cycles
        total = 0;
        for (int k = 0; k < 10; k++) begin
            store(24'h600 + 24'(k), 32'h12340000 + 32'(k), 1'b0, cyc);
            total += cyc;
        end
        chk("t8_total_cycles", DW'(total), DW'(11));
        tick();
        tick();
        expect_wr("t8a", 24'h600, 5,
                  {32'h12340000, 32'h12340001, 32'h12340002, 32'h12340003, 32'h12340004});
        expect_wr("t8b", 24'h605, 5,
                  {32'h12340005, 32'h12340006, 32'h12340007, 32'h12340008, 32'h12340009});
        expect_none("t8_no_extra");

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
